branch_pc_unit: RTL and testbench

- Program-counter and branch-resolution stage of the 16-bit CPU. Sits directly downstream of the NZP condition-code register and consumes its N/Z/P outputs.
- Holds the fetch PC, increments it each active cycle, and resolves conditional BR and unconditional JMP requests from decode.
- On a taken branch it redirects the PC and issues a one-cycle flush to squash the wrong-path instruction.
- Keeps a saturating taken-branch counter for debug.

---
 rtl/branch_pc_unit_if.sv | 30 +++
 rtl/branch_pc_unit.sv | 69 ++++++
 tb/tb_branch_pc_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/branch_pc_unit_if.sv
// Decode/condition-code side of the PC stage: redirect requests in, fetch PC and flush status out.
interface branch_pc_unit_if #(
  parameter int PC_WIDTH  = 16,
  parameter int OFF_WIDTH = 9
);
  logic                 stall;
  logic                 br_valid;
  logic [2:0]           br_nzp;
  logic [OFF_WIDTH-1:0] br_offset;
  logic [PC_WIDTH-1:0]  br_pc;
  logic                 jmp_valid;
  logic [PC_WIDTH-1:0]  jmp_target;
  logic                 N;
  logic                 Z;
  logic                 P;
  logic [PC_WIDTH-1:0]  pc;
  logic                 flush;
  logic                 taken;
  logic [15:0]          taken_cnt;

  modport master (
    output stall, br_valid, br_nzp, br_offset, br_pc, jmp_valid, jmp_target, N, Z, P,
    input  pc, flush, taken, taken_cnt
  );

  modport slave (
    input  stall, br_valid, br_nzp, br_offset, br_pc, jmp_valid, jmp_target, N, Z, P,
    output pc, flush, taken, taken_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Fetch PC with BR/JMP resolution; redirect lands one edge after acceptance, followed by one flush bubble.
// Stall freezes pc/state/counter and blocks acceptance; decode holds its request until stall drops.
module branch_pc_unit #(
  parameter int                  PC_WIDTH  = 16,
  parameter int                  OFF_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 16'h3000
) (
  input  logic             clk,
  input  logic             reset,
  branch_pc_unit_if.slave  bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]          state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                flush_q;
  logic                taken_q;
  logic [15:0]         cnt_q;

  logic                cond;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] target;
  logic                redirect;

  always_comb begin
    cond      = |(bus.br_nzp & {bus.N, bus.Z, bus.P});
    off_ext   = {{(PC_WIDTH-OFF_WIDTH){bus.br_offset[OFF_WIDTH-1]}}, bus.br_offset};
    br_target = bus.br_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1} + off_ext;
    // JMP wins if decode ever presents both at once
    target    = bus.jmp_valid ? bus.jmp_target : br_target;
    // The instruction sitting in decode during FLUSH is wrong-path, so nothing is accepted there
    redirect  = (state == ST_RUN) && (bus.jmp_valid || (bus.br_valid && cond));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else if (bus.stall) begin
      flush_q <= 1'b0;
      taken_q <= 1'b0;
    end else if (redirect) begin
      state   <= ST_FLUSH;
      pc_q    <= target;
      flush_q <= 1'b1;
      taken_q <= 1'b1;
      if (cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end else begin
      state   <= ST_RUN;
      pc_q    <= pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      flush_q <= 1'b0;
      taken_q <= 1'b0;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.flush     = flush_q;
  assign bus.taken     = taken_q;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: hand-computed PC, flush, taken and counter values after each edge.
module tb_branch_pc_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  branch_pc_unit_if #(.PC_WIDTH(16), .OFF_WIDTH(9)) bif ();

  branch_pc_unit #(.PC_WIDTH(16), .OFF_WIDTH(9), .RESET_PC(16'h3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_flush,
                         input logic e_taken, input logic [15:0] e_cnt);
    chk({tag, ".pc"},    bif.pc, e_pc);
    chk({tag, ".flush"}, {15'd0, bif.flush}, {15'd0, e_flush});
    chk({tag, ".taken"}, {15'd0, bif.taken}, {15'd0, e_taken});
    chk({tag, ".cnt"},   bif.taken_cnt, e_cnt);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bif.stall = 1'b0; bif.br_valid = 1'b0; bif.br_nzp = 3'b000; bif.br_offset = 9'd0;
    bif.br_pc = 16'h0; bif.jmp_valid = 1'b0; bif.jmp_target = 16'h0;
    bif.N = 1'b0; bif.Z = 1'b1; bif.P = 1'b0;

    // reset and free-running increment
    step(); chk_all("reset", 16'h3000, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    step(); chk_all("free1", 16'h3001, 1'b0, 1'b0, 16'd0);
    step(); chk_all("free2", 16'h3002, 1'b0, 1'b0, 16'd0);
    step(); chk_all("free3", 16'h3003, 1'b0, 1'b0, 16'd0);

    // Z=1 right after reset: BR z taken, 3003+1+5 = 3009
    bif.br_valid = 1'b1; bif.br_nzp = 3'b010; bif.br_pc = 16'h3003; bif.br_offset = 9'd5;
    step(); chk_all("br_z_taken", 16'h3009, 1'b1, 1'b1, 16'd1);
    bif.br_valid = 1'b0;
    step(); chk_all("br_z_bubble", 16'h300A, 1'b0, 1'b0, 16'd1);

    // N=1: mask 011 not taken, mask 100 taken to 3010+1-4 = 300D
    bif.N = 1'b1; bif.Z = 1'b0; bif.P = 1'b0;
    bif.br_valid = 1'b1; bif.br_nzp = 3'b011; bif.br_pc = 16'h300A; bif.br_offset = 9'h1FC;
    step(); chk_all("br_not_taken", 16'h300B, 1'b0, 1'b0, 16'd1);
    bif.br_nzp = 3'b100; bif.br_pc = 16'h3010;
    step(); chk_all("br_neg_off", 16'h300D, 1'b1, 1'b1, 16'd2);
    bif.br_valid = 1'b0;
    step(); chk_all("br_neg_bubble", 16'h300E, 1'b0, 1'b0, 16'd2);

    // mask 000 never taken even with a code set
    bif.br_valid = 1'b1; bif.br_nzp = 3'b000;
    step(); chk_all("br_mask0", 16'h300F, 1'b0, 1'b0, 16'd2);

    // JMP beats BR; BR with 111 in the FLUSH cycle is ignored
    bif.jmp_valid = 1'b1; bif.jmp_target = 16'h4000;
    bif.br_nzp = 3'b111; bif.br_pc = 16'h301F; bif.br_offset = 9'd0;
    step(); chk_all("jmp_prio", 16'h4000, 1'b1, 1'b1, 16'd3);
    bif.jmp_valid = 1'b0;
    step(); chk_all("flush_ignores_br", 16'h4001, 1'b0, 1'b0, 16'd3);

    // stall holds everything with a taken BR pending: target 4001+1+16 = 4012
    bif.stall = 1'b1; bif.br_pc = 16'h4001; bif.br_offset = 9'h010;
    step(); chk_all("stall1", 16'h4001, 1'b0, 1'b0, 16'd3);
    step(); chk_all("stall2", 16'h4001, 1'b0, 1'b0, 16'd3);
    step(); chk_all("stall3", 16'h4001, 1'b0, 1'b0, 16'd3);
    bif.stall = 1'b0;
    step(); chk_all("stall_release", 16'h4012, 1'b1, 1'b1, 16'd4);
    bif.br_valid = 1'b0;
    step(); chk_all("stall_bubble", 16'h4013, 1'b0, 1'b0, 16'd4);

    // stall during FLUSH holds state, bubble still follows
    bif.jmp_valid = 1'b1; bif.jmp_target = 16'h5000;
    step(); chk_all("jmp5000", 16'h5000, 1'b1, 1'b1, 16'd5);
    bif.jmp_valid = 1'b0; bif.stall = 1'b1;
    step(); chk_all("stall_in_flush", 16'h5000, 1'b0, 1'b0, 16'd5);
    bif.stall = 1'b0; bif.jmp_valid = 1'b1;
    step(); chk_all("flush_after_stall", 16'h5001, 1'b0, 1'b0, 16'd5);

    // PC wrap FFFF -> 0000
    bif.jmp_target = 16'hFFFE;
    step(); chk_all("jmp_fffe", 16'hFFFE, 1'b1, 1'b1, 16'd6);
    bif.jmp_valid = 1'b0;
    step(); chk_all("pc_ffff", 16'hFFFF, 1'b0, 1'b0, 16'd6);
    step(); chk_all("pc_wrap", 16'h0000, 1'b0, 1'b0, 16'd6);

    // BR target wrap: FFFE+1+1 = 0000
    bif.br_valid = 1'b1; bif.br_nzp = 3'b111; bif.br_pc = 16'hFFFE; bif.br_offset = 9'd1;
    step(); chk_all("br_target_wrap", 16'h0000, 1'b1, 1'b1, 16'd7);
    bif.br_valid = 1'b0;

    // reset in the FLUSH cycle, together with stall
    reset = 1'b1; bif.stall = 1'b1;
    step(); chk_all("reset_in_flush", 16'h3000, 1'b0, 1'b0, 16'd0);
    reset = 1'b0; bif.stall = 1'b0;
    step(); chk_all("after_reset", 16'h3001, 1'b0, 1'b0, 16'd0);

    // counter saturation: preload FFFE while stalled, then two more jumps
    bif.stall = 1'b1;
    force dut.cnt_q = 16'hFFFE;
    step();
    release dut.cnt_q;
    step(); chk_all("cnt_preload", 16'h3001, 1'b0, 1'b0, 16'hFFFE);
    bif.stall = 1'b0; bif.jmp_valid = 1'b1; bif.jmp_target = 16'h1234;
    step(); chk_all("cnt_to_max", 16'h1234, 1'b1, 1'b1, 16'hFFFF);
    step(); chk_all("cnt_max_bubble", 16'h1235, 1'b0, 1'b0, 16'hFFFF);
    step(); chk_all("cnt_saturate", 16'h1234, 1'b1, 1'b1, 16'hFFFF);
    bif.jmp_valid = 1'b0;
    step(); chk_all("cnt_sat_bubble", 16'h1235, 1'b0, 1'b0, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
